ex_mul_div_unit: RTL and testbench
==================================

// Module: ex_mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline registers (ex_registerRs/ex_registerRt).
//  Executes MULT/MULTU/DIV/DIVU into HI/LO over WIDTH+1 cycles; busy stalls IF/ID/EX while an op is in flight.
//  Also services MTHI/MTLO writes. HI/LO are read combinationally by MFHI/MFLO in EX.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      asynchronous, active-low (0 = reset)
//  start       in   1      EX holds a mul/div op this cycle
//  operation   in   2      0=MULT 1=MULTU 2=DIV 3=DIVU
//  operandA    in   WIDTH  rs value (multiplicand / dividend)
//  operandB    in   WIDTH  rt value (multiplier / divisor)
//  flush       in   1      branch/jump taken in MEM; kill in-flight op
//  mtWrite     in   1      MTHI/MTLO this cycle
//  mtSelectHi  in   1      1=write HI, 0=write LO
//  mtData      in   WIDTH  data for MTHI/MTLO
//  busy        out  1      op in flight; pipeline must stall
//  done        out  1      one-cycle pulse: HI/LO just updated by an op
//  hi          out  WIDTH  HI register
//  lo          out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, hi=lo=0, busy=0, done=0, all datapath regs 0. Reset mid-op aborts it.
//  - States: IDLE -> MUL or DIV (on accept) -> FINISH -> IDLE.
//  - Accept: edge where state=IDLE, start=1, flush=0, mtWrite=0. Captures |A|,|B| (signed ops) or raw (unsigned),
//    plus sign flags sQ=sA^sB, sR=sA. Iteration counter loaded with WIDTH.
//  - MUL: radix-2 shift-add, one bit per cycle, 2*WIDTH-bit product accumulator.
//  - DIV: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
//  - After WIDTH iteration edges -> FINISH; next edge applies sign fix-up, writes hi/lo, returns to IDLE.
//  - Latency: busy=1 for exactly WIDTH+1 cycles following the accept edge; done=1 for the single cycle after the
//    hi/lo write edge (busy=0 in that cycle). busy is a registered output.
//  - Results: MULT(U): {hi,lo} = 2*WIDTH-bit product, negated if sQ (signed only).
//    DIV(U): lo = quotient (negated if sQ), hi = remainder (negated if sR).
//  - Divide by zero: lo = all ones, hi = operandA (as captured, signs ignored). Still WIDTH+1 cycles unless macro.
//  - Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000 (WIDTH=32), hi = 0. Must fall out of the abs/negate path.
//  - start while busy: ignored (EX is stalled, op re-presented is the same in-flight op).
//  - flush while busy: op aborted at that edge; state=IDLE, busy=0 next cycle, hi/lo unchanged, no done.
//  - flush and start same cycle in IDLE: start dropped.
//  - mtWrite in IDLE: selected register <= mtData at edge; start in same cycle ignored. mtWrite while busy: ignored.
//  - hi/lo change only on: reset, mtWrite accept, FINISH write.
// CONFIGURATION
//  MUL_DIV_EARLY_OUT_EN defined: at accept, if operandB==0 (any op) or operandA==0 (MULT/MULTU), skip iterations:
//    state goes directly to FINISH; busy=1 for 1 cycle, done one cycle later; results as specified above.
//  Not defined: every accepted op takes the full WIDTH+1 busy cycles; no zero detection beyond div-by-zero result.
// TESTING
//  MULT A=-3 B=7 -> busy 33 cycles, done pulse, hi=0xFFFFFFFF lo=0xFFFFFFEB.
//  MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  DIV A=-7 B=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU A=100 B=0 -> lo=0xFFFFFFFF hi=100 (busy 1 cycle with EARLY_OUT).
//  DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  Start MULT, flush at busy cycle 10 -> busy=0 next cycle, hi/lo keep prior MTHI/MTLO values (0x1234/0x5678), no done.
//  Assert reset=0 mid-DIVU -> busy=0, done=0, hi=lo=0 immediately; start+mtWrite in IDLE -> only mtWrite takes effect.

Source files
------------

// File: rtl/ex_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mul_div_unit
//  Description : Iterative EX-stage multiply/divide unit (shift-add multiply,
//                restoring divide) owning the HI/LO registers, including
//                MTHI/MTLO writes. Optional macro MUL_DIV_EARLY_OUT_EN skips
//                the iterations when an operand makes the result trivial.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             flush,
    input  logic             mtWrite,
    input  logic             mtSelectHi,
    input  logic [WIDTH-1:0] mtData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MUL    = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam int                CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_ITER = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]  C_ONES = '1;

    logic [1:0]         rState;
    logic [1:0]         wStateNext;
    logic [CNT_W-1:0]   rCount;
    logic [2*WIDTH-1:0] rAcc;      // MUL: product; DIV: low half holds dividend/quotient
    logic [WIDTH-1:0]   rRem;
    logic [WIDTH-1:0]   rOpA;
    logic [WIDTH-1:0]   rOpB;
    logic               rSignQ;
    logic               rSignR;
    logic               rIsDiv;

    logic               wSigned;
    logic               wNegA;
    logic               wNegB;
    logic [WIDTH-1:0]   wAbsA;
    logic [WIDTH-1:0]   wAbsB;
    logic               wAccept;
    logic               wMtAccept;
    logic               wSkip;
    logic               wIterate;
    logic               wWrite;
    logic               wBusyNext;
    logic [WIDTH:0]     wSum;
    logic [WIDTH:0]     wShift;
    logic [WIDTH:0]     wDiff;
    logic               wGe;
    logic [2*WIDTH-1:0] wProd;
    logic [WIDTH-1:0]   wQuo;
    logic [WIDTH-1:0]   wRemOut;

    assign wSigned   = ~operation[0];
    assign wNegA     = wSigned & operandA[WIDTH-1];
    assign wNegB     = wSigned & operandB[WIDTH-1];
    assign wAbsA     = wNegA ? -operandA : operandA;
    assign wAbsB     = wNegB ? -operandB : operandB;
    assign wAccept   = (rState == IDLE) & start & ~flush & ~mtWrite;
    assign wMtAccept = (rState == IDLE) & mtWrite;

`ifdef MUL_DIV_EARLY_OUT_EN
    assign wSkip = (operandB == '0) | (~operation[1] & (operandA == '0));
`else
    assign wSkip = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rState <= IDLE;
        end else begin
            rState <= wStateNext;
        end
    end

    // Next-state logic
    always_comb begin
        wStateNext = rState;
        case (rState)
            IDLE: begin
                if (wAccept) begin
                    if (wSkip)             wStateNext = FINISH;
                    else if (operation[1]) wStateNext = DIV;
                    else                   wStateNext = MUL;
                end
            end
            MUL, DIV: begin
                if (flush)                wStateNext = IDLE;
                else if (rCount == C_ONE) wStateNext = FINISH;
            end
            FINISH:  wStateNext = IDLE;
            default: wStateNext = IDLE;
        endcase
    end

    // Output/control decode
    always_comb begin
        wIterate  = ((rState == MUL) | (rState == DIV)) & ~flush;
        wWrite    = (rState == FINISH) & ~flush;
        wBusyNext = (wStateNext != IDLE);
    end

    // Shift-add step: add multiplicand into the upper half, then shift right
    assign wSum   = {1'b0, rAcc[2*WIDTH-1:WIDTH]} + (rAcc[0] ? {1'b0, rOpA} : '0);
    // Restoring step: shift in next dividend bit, subtract if it fits
    assign wShift = {rRem, rAcc[WIDTH-1]};
    assign wGe    = (wShift >= {1'b0, rOpB});
    assign wDiff  = wShift - {1'b0, rOpB};

    assign wProd   = rSignQ ? -rAcc : rAcc;
    assign wQuo    = rSignQ ? -rAcc[WIDTH-1:0] : rAcc[WIDTH-1:0];
    assign wRemOut = rSignR ? -rRem : rRem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rCount <= '0;
            rAcc   <= '0;
            rRem   <= '0;
            rOpA   <= '0;
            rOpB   <= '0;
            rSignQ <= 1'b0;
            rSignR <= 1'b0;
            rIsDiv <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= wBusyNext;
            done <= wWrite;
            if (wAccept) begin
                rCount <= C_ITER;
                rOpA   <= wAbsA;
                rOpB   <= wAbsB;
                rSignQ <= wNegA ^ wNegB;
                rSignR <= wNegA;
                rIsDiv <= operation[1];
                rRem   <= '0;
                // A skipped multiply has a zero operand, so its product is zero
                rAcc   <= (wSkip & ~operation[1]) ? '0 : {{WIDTH{1'b0}}, operation[1] ? wAbsA : wAbsB};
            end else if (wIterate) begin
                rCount <= rCount - C_ONE;
                if (rState == MUL) begin
                    rAcc <= {wSum, rAcc[WIDTH-1:1]};
                end else begin
                    rRem             <= wGe ? wDiff[WIDTH-1:0] : wShift[WIDTH-1:0];
                    rAcc[WIDTH-1:0]  <= {rAcc[WIDTH-2:0], wGe};
                end
            end
            if (wMtAccept) begin
                if (mtSelectHi) hi <= mtData;
                else            lo <= mtData;
            end else if (wWrite) begin
                if (!rIsDiv) begin
                    {hi, lo} <= wProd;
                end else if (rOpB == '0) begin
                    lo <= C_ONES;
                    hi <= rOpA;
                end else begin
                    lo <= wQuo;
                    hi <= wRemOut;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mul_div_unit
//  Description : Directed self-checking bench for ex_mul_div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mul_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT_FULL = WIDTH + 1;
`ifdef MUL_DIV_EARLY_OUT_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = WIDTH + 1;
`endif

    logic             clock;
    logic             reset;
    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             flush;
    logic             mtWrite;
    logic             mtSelectHi;
    logic [WIDTH-1:0] mtData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    ex_mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .operation  (operation),
        .operandA   (operandA),
        .operandB   (operandB),
        .flush      (flush),
        .mtWrite    (mtWrite),
        .mtSelectHi (mtSelectHi),
        .mtData     (mtData),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one op, measure busy length, then check done pulse and HI/LO
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input logic [31:0] expHi, input logic [31:0] expLo);
        int cnt;
        @(negedge clock);
        start = 1'b1; operation = op; operandA = a; operandB = b;
        @(negedge clock);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        check({tag, "_latency"}, cnt, expLat);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_hi"}, hi, expHi);
        check({tag, "_lo"}, lo, expLo);
        @(negedge clock);
        check({tag, "_done_clear"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; operation = 2'd0; operandA = '0; operandB = '0;
        flush = 1'b0; mtWrite = 1'b0; mtSelectHi = 1'b0; mtData = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b1;

        runOp("mult_neg",   2'd0, 32'hFFFF_FFFD, 32'd7,        LAT_FULL, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("multu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_FULL, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("multu_2_32", 2'd1, 32'h0001_0000, 32'h0001_0000, LAT_FULL, 32'h0000_0001, 32'h0000_0000);
        runOp("div_neg",    2'd2, 32'hFFFF_FFF9, 32'd2,        LAT_FULL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_7",     2'd3, 32'd100,       32'd7,        LAT_FULL, 32'd2,         32'd14);
        runOp("divu_zero",  2'd3, 32'd100,       32'd0,        LAT_ZERO, 32'd100,       32'hFFFF_FFFF);
        runOp("div_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, LAT_FULL, 32'h0,        32'h8000_0000);
        runOp("mult_zero",  2'd0, 32'd0,         32'd5,        LAT_ZERO, 32'h0,         32'h0);

        // MTHI / MTLO
        @(negedge clock);
        mtWrite = 1'b1; mtSelectHi = 1'b1; mtData = 32'h1234;
        @(negedge clock);
        mtSelectHi = 1'b0; mtData = 32'h5678;
        @(negedge clock);
        mtWrite = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);

        // Flush at busy cycle 10
        start = 1'b1; operation = 2'd0; operandA = 32'd5; operandB = 32'd6;
        @(negedge clock);
        start = 1'b0;
        check("flush_busy_pre", {31'b0, busy}, 32'd1);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        check("flush_done_later", {31'b0, done}, 32'd0);
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'h5678);

        // Flush and start together in IDLE: start dropped
        start = 1'b1; flush = 1'b1; operation = 2'd1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'd0);

        // Async reset mid-DIVU
        start = 1'b1; operation = 2'd3; operandA = 32'd1000; operandB = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // start + mtWrite in IDLE: only the write happens
        @(negedge clock);
        start = 1'b1; operation = 2'd1; operandA = 32'd3; operandB = 32'd3;
        mtWrite = 1'b1; mtSelectHi = 1'b0; mtData = 32'hABCD;
        @(negedge clock);
        start = 1'b0; mtWrite = 1'b0;
        check("mt_start_busy", {31'b0, busy}, 32'd0);
        check("mt_start_lo", lo, 32'hABCD);
        check("mt_start_hi", hi, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
